// File: rtl/add_layer_sched_if.sv
// Handshake and configuration bundle between the add-layer channel sequencer
// and its surroundings: branch FIFOs, add layer, downstream consumer, control.
interface add_layer_sched_if #(
   parameter int INWIDTH      = 16,
   parameter int HEIGHT_WIDTH = 5,
   parameter int CH_WIDTH     = 8,
   parameter int OVFL_WIDTH   = 16
);
   // control / status
   logic                     en;
   logic [HEIGHT_WIDTH-1:0]  cfg_h;
   logic [HEIGHT_WIDTH-1:0]  cfg_w;
   logic [CH_WIDTH-1:0]      cfg_c;
   logic                     cmd_start;
   logic                     busy;
   logic                     done;
   logic [OVFL_WIDTH-1:0]    ovfl_cnt;
   // skip-branch (A) and main-branch (B) streams
   logic signed [INWIDTH-1:0] a_din;
   logic                      a_vld;
   logic                      a_rdy;
   logic signed [INWIDTH-1:0] b_din;
   logic                      b_vld;
   logic                      b_rdy;
   // add layer side
   logic                      add_start;
   logic [HEIGHT_WIDTH-1:0]   add_h;
   logic [HEIGHT_WIDTH-1:0]   add_w;
   logic signed [INWIDTH-1:0] add_din;
   logic                      add_din_vld;
   logic                      add_din_rdy;
   logic signed [INWIDTH-1:0] add_dout;
   logic                      add_dout_ovfl;
   logic                      add_dout_vld;
   logic                      add_dout_rdy;
   // consumer side
   logic signed [INWIDTH-1:0] y_dout;
   logic                      y_ovfl;
   logic                      y_vld;
   logic                      y_rdy;

   modport slave (
      input  en, cfg_h, cfg_w, cfg_c, cmd_start,
      output busy, done, ovfl_cnt,
      input  a_din, a_vld, output a_rdy,
      input  b_din, b_vld, output b_rdy,
      output add_start, add_h, add_w, add_din, add_din_vld,
      input  add_din_rdy,
      input  add_dout, add_dout_ovfl, add_dout_vld,
      output add_dout_rdy,
      output y_dout, y_ovfl, y_vld,
      input  y_rdy
   );

   modport master (
      output en, cfg_h, cfg_w, cfg_c, cmd_start,
      input  busy, done, ovfl_cnt,
      output a_din, a_vld, input a_rdy,
      output b_din, b_vld, input b_rdy,
      input  add_start, add_h, add_w, add_din, add_din_vld,
      output add_din_rdy,
      output add_dout, add_dout_ovfl, add_dout_vld,
      input  add_dout_rdy,
      input  y_dout, y_ovfl, y_vld,
      output y_rdy
   );
endinterface

// File: rtl/add_layer_sched.sv
// Channel-loop sequencer for the element-wise add layer (residual join).
// Per channel: pulse the layer start, stream the A map then the B map into the
// layer's single input, then drain H*W results to the consumer. All data paths
// are combinational pass-throughs; only control and counters are registered.
module add_layer_sched #(
   parameter int INWIDTH      = 16,
   parameter int HEIGHT_WIDTH = 5,
   parameter int CH_WIDTH     = 8,
   parameter int OVFL_WIDTH   = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   add_layer_sched_if.slave  bus
);
   localparam int EW = 2 * HEIGHT_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_SEND_A, S_SEND_B, S_DRAIN, S_FIN
   } state_t;

   state_t                  state_q;
   logic [HEIGHT_WIDTH-1:0] h_q;
   logic [HEIGHT_WIDTH-1:0] w_q;
   logic [CH_WIDTH-1:0]     c_q;
   logic [CH_WIDTH-1:0]     ch_cnt_q;
   logic [EW-1:0]           hw_q;
   logic [EW-1:0]           elem_cnt_q;
   logic [OVFL_WIDTH-1:0]   ovfl_cnt_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    add_start_q;

   logic in_a, in_b, in_drain;
   logic a_xfer, b_xfer, y_xfer;
   logic last_elem, last_ch, cfg_zero;

   assign in_a     = (state_q == S_SEND_A);
   assign in_b     = (state_q == S_SEND_B);
   assign in_drain = (state_q == S_DRAIN);

   // Ready paths depend only on the opposite side's ready, never on own valid;
   // valids are gated with EN so nothing can be seen to transfer while frozen.
   assign bus.a_rdy        = in_a & bus.add_din_rdy & bus.en;
   assign bus.b_rdy        = in_b & bus.add_din_rdy & bus.en;
   assign bus.add_din      = in_a ? bus.a_din : (in_b ? bus.b_din : '0);
   assign bus.add_din_vld  = bus.en & ((in_a & bus.a_vld) | (in_b & bus.b_vld));
   assign bus.add_dout_rdy = in_drain & bus.y_rdy & bus.en;
   assign bus.y_dout       = in_drain ? bus.add_dout : '0;
   assign bus.y_ovfl       = in_drain & bus.add_dout_ovfl;
   assign bus.y_vld        = in_drain & bus.add_dout_vld & bus.en;

   assign a_xfer = bus.a_vld & bus.a_rdy;
   assign b_xfer = bus.b_vld & bus.b_rdy;
   assign y_xfer = bus.add_dout_vld & bus.add_dout_rdy;

   assign last_elem = (elem_cnt_q == (hw_q - EW'(1)));
   assign last_ch   = (ch_cnt_q == (c_q - CH_WIDTH'(1)));
   assign cfg_zero  = (bus.cfg_h == '0) | (bus.cfg_w == '0) | (bus.cfg_c == '0);

   // ADD_START is masked while frozen; the registered pulse resumes with EN.
   assign bus.add_start = add_start_q & bus.en;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.add_h     = h_q;
   assign bus.add_w     = w_q;
   assign bus.ovfl_cnt  = ovfl_cnt_q;

   // Sequencer FSM with its counters and registered status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         w_q         <= '0;
         c_q         <= '0;
         ch_cnt_q    <= '0;
         hw_q        <= '0;
         elem_cnt_q  <= '0;
         ovfl_cnt_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         add_start_q <= 1'b0;
      end else if (bus.en) begin
         done_q      <= 1'b0;
         add_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_start) begin
                  h_q        <= bus.cfg_h;
                  w_q        <= bus.cfg_w;
                  c_q        <= bus.cfg_c;
                  hw_q       <= EW'(bus.cfg_h) * EW'(bus.cfg_w);
                  ovfl_cnt_q <= '0;
                  ch_cnt_q   <= '0;
                  elem_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  if (cfg_zero) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= S_LAUNCH;
                     add_start_q <= 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               elem_cnt_q <= '0;
               state_q    <= S_SEND_A;
            end
            S_SEND_A: begin
               if (a_xfer) begin
                  if (last_elem) begin
                     elem_cnt_q <= '0;
                     state_q    <= S_SEND_B;
                  end else begin
                     elem_cnt_q <= elem_cnt_q + EW'(1);
                  end
               end
            end
            S_SEND_B: begin
               if (b_xfer) begin
                  if (last_elem) begin
                     elem_cnt_q <= '0;
                     state_q    <= S_DRAIN;
                  end else begin
                     elem_cnt_q <= elem_cnt_q + EW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (y_xfer) begin
                  if (bus.add_dout_ovfl && (ovfl_cnt_q != '1)) begin
                     ovfl_cnt_q <= ovfl_cnt_q + OVFL_WIDTH'(1);
                  end
                  if (last_elem) begin
                     elem_cnt_q <= '0;
                     if (last_ch) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                     end else begin
                        ch_cnt_q    <= ch_cnt_q + CH_WIDTH'(1);
                        state_q     <= S_LAUNCH;
                        add_start_q <= 1'b1;
                     end
                  end else begin
                     elem_cnt_q <= elem_cnt_q + EW'(1);
                  end
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_add_layer_sched.sv
// Directed bench for add_layer_sched: models branch FIFOs, the add layer and
// the consumer with queues, and checks ordering, counts and timing.
module tb_add_layer_sched;
   localparam int IW = 16;
   localparam int HW = 5;
   localparam int CW = 8;
   localparam int OW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   add_layer_sched_if #(.INWIDTH(IW), .HEIGHT_WIDTH(HW), .CH_WIDTH(CW), .OVFL_WIDTH(OW)) bus ();

   add_layer_sched #(.INWIDTH(IW), .HEIGHT_WIDTH(HW), .CH_WIDTH(CW), .OVFL_WIDTH(OW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic signed [IW-1:0] a_q[$], b_q[$], exp_din[$], exp_y[$], layer_in[$], res_q[$];
   bit exp_yo[$], res_o[$], ovfl_plan[$];

   int cur_n = 0;
   int gap = 0;
   bit en_v = 1'b1;
   bit cmd_v = 1'b0;
   logic [HW-1:0] h_v = '0;
   logic [HW-1:0] w_v = '0;
   logic [CW-1:0] c_v = '0;

   int starts = 0, dones = 0, ycnt = 0, dcnt = 0, rdy_seen = 0, en0_events = 0;
   int done_cyc = -1, last_y_cyc = -1, start_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      bit ax, bx, dx, ox, yx, st;
      logic signed [IW-1:0] dval;
      logic signed [IW-1:0] s;
      bus.en        = en_v;
      bus.cmd_start = cmd_v;
      bus.cfg_h     = h_v;
      bus.cfg_w     = w_v;
      bus.cfg_c     = c_v;
      bus.a_vld     = (a_q.size() > 0) && ($urandom_range(99) >= gap);
      bus.a_din     = (a_q.size() > 0) ? a_q[0] : '0;
      bus.b_vld     = (b_q.size() > 0) && ($urandom_range(99) >= gap);
      bus.b_din     = (b_q.size() > 0) ? b_q[0] : '0;
      bus.add_din_rdy   = ($urandom_range(99) >= gap);
      bus.add_dout_vld  = (res_q.size() > 0) && ($urandom_range(99) >= gap);
      bus.add_dout      = (res_q.size() > 0) ? res_q[0] : '0;
      bus.add_dout_ovfl = (res_o.size() > 0) ? res_o[0] : 1'b0;
      bus.y_rdy         = ($urandom_range(99) >= gap);
      @(negedge clk);
      ax = bus.a_vld && bus.a_rdy;
      bx = bus.b_vld && bus.b_rdy;
      dx = bus.add_din_vld && bus.add_din_rdy;
      ox = bus.add_dout_vld && bus.add_dout_rdy;
      yx = bus.y_vld && bus.y_rdy;
      st = bus.add_start;
      dval = bus.add_din;
      if (st) starts++;
      if (bus.done) begin dones++; done_cyc = cyc; end
      if (bus.a_rdy || bus.b_rdy || bus.add_dout_rdy) rdy_seen++;
      if (!en_v && (ax || bx || dx || ox || yx || st)) en0_events++;
      if (ax || bx || dx) chk("din_pass", {ax && bx, dx}, {1'b0, ax || bx});
      if (ox || yx) chk("y_pass", yx, ox);
      if (dx) begin
         dcnt++;
         chk("din_avail", exp_din.size() > 0, 1);
         if (exp_din.size() > 0) chk("din_data", bus.add_din, exp_din.pop_front());
      end
      if (yx) begin
         ycnt++;
         last_y_cyc = cyc;
         chk("y_avail", exp_y.size() > 0, 1);
         if (exp_y.size() > 0) begin
            chk("y_data", bus.y_dout, exp_y.pop_front());
            chk("y_ovfl", bus.y_ovfl, exp_yo.pop_front());
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ax) void'(a_q.pop_front());
      if (bx) void'(b_q.pop_front());
      if (st) layer_in.delete();
      if (dx) layer_in.push_back(dval);
      if (cur_n > 0 && layer_in.size() == 2 * cur_n) begin
         for (int i = 0; i < cur_n; i++) begin
            s = layer_in[i] + layer_in[i + cur_n];
            res_q.push_back(s);
            res_o.push_back((ovfl_plan.size() > 0) ? ovfl_plan.pop_front() : 1'b0);
         end
         layer_in.delete();
      end
      if (ox) begin
         void'(res_q.pop_front());
         void'(res_o.pop_front());
      end
   endtask

   task automatic load_job(input int h, input int w, input int c, input int g, input int mask);
      logic signed [IW-1:0] av, bv;
      cur_n = h * w;
      gap = g;
      h_v = HW'(h);
      w_v = HW'(w);
      c_v = CW'(c);
      if (cur_n > 0) begin
         for (int ch = 0; ch < c; ch++) begin
            for (int i = 0; i < cur_n; i++) begin
               av = IW'(ch * 8 + i + 1);
               a_q.push_back(av);
               exp_din.push_back(av);
            end
            for (int i = 0; i < cur_n; i++) begin
               av = IW'(ch * 8 + i + 1);
               bv = IW'(10 * (i + 1) + ch);
               b_q.push_back(bv);
               exp_din.push_back(bv);
               exp_y.push_back(av + bv);
               exp_yo.push_back(mask[i % 32]);
               ovfl_plan.push_back(mask[i % 32]);
            end
         end
      end
   endtask

   task automatic start_job();
      start_cyc = cyc;
      cmd_v = 1'b1;
      cycle();
      cmd_v = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int d0 = dones;
      int k = 0;
      while (dones == d0 && k < budget) begin
         cycle();
         k++;
      end
      repeat (3) cycle();
      chk({tag, "_single_done"}, dones - d0, 1);
   endtask

   task automatic flush_model();
      a_q.delete(); b_q.delete(); exp_din.delete(); exp_y.delete(); exp_yo.delete();
      layer_in.delete(); res_q.delete(); res_o.delete(); ovfl_plan.delete();
   endtask

   int s0, d0, y0, r0, e0, k;

   initial begin
      // reset state
      rst = 1'b1;
      repeat (2) cycle();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_add_start", bus.add_start, 0);
      chk("rst_rdys", {bus.a_rdy, bus.b_rdy, bus.add_dout_rdy}, 0);
      chk("rst_vlds", {bus.add_din_vld, bus.y_vld}, 0);
      chk("rst_hw", {bus.add_h, bus.add_w}, 0);
      chk("rst_ovfl", bus.ovfl_cnt, 0);
      rst = 1'b0;
      repeat (2) cycle();

      // H=2 W=3 C=1, no gaps
      load_job(2, 3, 1, 0, 0);
      s0 = starts; d0 = dcnt; y0 = ycnt;
      start_job();
      chk("t1_busy", bus.busy, 1);
      chk("t1_add_h", bus.add_h, 2);
      chk("t1_add_w", bus.add_w, 3);
      run_until_done(200, "t1");
      chk("t1_starts", starts - s0, 1);
      chk("t1_din_cnt", dcnt - d0, 12);
      chk("t1_y_cnt", ycnt - y0, 6);
      chk("t1_done_lat", done_cyc, last_y_cyc + 1);
      chk("t1_left", exp_y.size() + exp_din.size(), 0);
      chk("t1_idle", bus.busy, 0);

      // H=5 W=5 C=4 with random gaps
      load_job(5, 5, 4, 30, 0);
      s0 = starts; d0 = dcnt; y0 = ycnt;
      start_job();
      run_until_done(4000, "t2");
      chk("t2_starts", starts - s0, 4);
      chk("t2_din_cnt", dcnt - d0, 200);
      chk("t2_y_cnt", ycnt - y0, 100);
      chk("t2_left", exp_y.size() + exp_din.size(), 0);
      chk("t2_add_h", bus.add_h, 5);

      // zero height with C=3
      load_job(0, 5, 3, 0, 0);
      s0 = starts; r0 = rdy_seen;
      start_job();
      run_until_done(20, "t3");
      chk("t3_starts", starts - s0, 0);
      chk("t3_rdy", rdy_seen - r0, 0);
      chk("t3_done_lat", done_cyc - start_cyc, 1);

      // overflow flags on 7 of 9 outputs, then restart clears
      load_job(3, 3, 1, 0, 32'h1DD);
      start_job();
      run_until_done(200, "t4");
      chk("t4_ovfl_cnt", bus.ovfl_cnt, 7);
      load_job(1, 1, 1, 0, 0);
      start_job();
      chk("t4_ovfl_clear", bus.ovfl_cnt, 0);
      run_until_done(50, "t4b");
      chk("t4_ovfl_after", bus.ovfl_cnt, 0);

      // EN low mid SEND_B, then reset mid DRAIN
      load_job(3, 3, 1, 0, 0);
      d0 = dcnt; y0 = ycnt; s0 = dones;
      start_job();
      k = 0;
      while (dcnt - d0 < 11 && k < 100) begin cycle(); k++; end
      chk("t5_reach_b", dcnt - d0, 11);
      en_v = 1'b0;
      e0 = en0_events;
      repeat (10) cycle();
      chk("t5_en0_events", en0_events - e0, 0);
      chk("t5_en0_frozen", dcnt - d0, 11);
      chk("t5_en0_busy", bus.busy, 1);
      en_v = 1'b1;
      k = 0;
      while (ycnt - y0 < 3 && k < 100) begin cycle(); k++; end
      chk("t5_reach_drain", ycnt - y0, 3);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_y_vld", bus.y_vld, 0);
      chk("t5_rst_rdys", {bus.a_rdy, bus.b_rdy, bus.add_dout_rdy}, 0);
      chk("t5_rst_din_vld", bus.add_din_vld, 0);
      chk("t5_rst_hw", {bus.add_h, bus.add_w}, 0);
      repeat (2) cycle();
      rst = 1'b0;
      flush_model();
      repeat (4) cycle();
      chk("t5_no_done", dones - s0, 0);
      chk("t5_idle", bus.busy, 0);

      // CMD_START while busy is ignored
      load_job(2, 2, 1, 0, 0);
      s0 = starts; y0 = ycnt; d0 = dones;
      start_job();
      repeat (2) cycle();
      h_v = 5'd7; w_v = 5'd9; c_v = 8'd2;
      cmd_v = 1'b1;
      cycle();
      cmd_v = 1'b0;
      chk("t6_add_h_busy", bus.add_h, 2);
      chk("t6_add_w_busy", bus.add_w, 2);
      run_until_done(100, "t6");
      chk("t6_starts", starts - s0, 1);
      chk("t6_y_cnt", ycnt - y0, 4);
      chk("t6_add_hw_end", {bus.add_h, bus.add_w}, {5'd2, 5'd2});
      chk("t6_idle", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
